// File: rtl/booth_mult_if.sv
// Operand/product handshake bundle for the iterative Booth multiplier.
// The slave side is the multiplier; the master side supplies operands and consumes products.
interface booth_mult_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth_mult_sequencer.sv
// Iterative radix-4 Booth multiplier: one shared digit decoder, one Booth digit per cycle,
// shifted partial products accumulated into a signed accumulator, result via valid/ready.
module booth_mult_sequencer #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 0
) (
  input  logic         clk,
  input  logic         rst,
  booth_mult_if.slave  bus
);

  localparam int DIGITS = WIDTH / 2 + 1;
  localparam int XS_W   = 2 * DIGITS;
  localparam int PP_W   = WIDTH + 2;
  localparam int ACC_W  = 2 * WIDTH + 2;
  localparam int CNT_W  = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                   state;
  logic [XS_W-1:0]          xs;
  logic                     prev;
  logic [WIDTH-1:0]         yr;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         cnt;

  logic [2:0]               digit;
  logic signed [PP_W-1:0]   pp;
  logic signed [ACC_W-1:0]  pp_ext;
  logic signed [ACC_W-1:0]  acc_next;
  logic [XS_W-1:0]          xs_shift;
  logic                     last_digit;

  // Radix-4 Booth recoding of one digit {x[2i+1], x[2i], x[2i-1]} into a signed multiple of m.
  function automatic logic signed [PP_W-1:0] booth_pp(input logic [2:0] d,
                                                      input logic [WIDTH-1:0] m);
    logic signed [PP_W-1:0] m1;
    logic signed [PP_W-1:0] m2;
    m1 = signed'({2'b00, m});
    m2 = signed'({1'b0, m, 1'b0});
    case (d)
      3'b001, 3'b010: booth_pp = m1;
      3'b011:         booth_pp = m2;
      3'b100:         booth_pp = -m2;
      3'b101, 3'b110: booth_pp = -m1;
      default:        booth_pp = '0;
    endcase
  endfunction

  always_comb begin
    digit    = {xs[1:0], prev};
    pp       = booth_pp(digit, yr);
    pp_ext   = {{(ACC_W-PP_W){pp[PP_W-1]}}, pp};
    acc_next = acc + (pp_ext <<< {cnt, 1'b0});
    xs_shift = xs >> 2;
    // Early exit: the bit just consumed and everything above it are zero, so all later digits are 000.
    last_digit = (cnt == LAST_CNT) ||
                 ((EARLY_EXIT != 0) && (xs_shift == '0) && !xs[1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      xs            <= '0;
      prev          <= 1'b0;
      yr            <= '0;
      acc           <= '0;
      cnt           <= '0;
      bus.product   <= '0;
      bus.out_valid <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            xs           <= {2'b00, bus.x};
            prev         <= 1'b0;
            yr           <= bus.y;
            acc          <= '0;
            cnt          <= '0;
            state        <= RUN;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        RUN: begin
          acc  <= acc_next;
          prev <= xs[1];
          xs   <= xs_shift;
          cnt  <= cnt + CNT_W'(1);
          if (last_digit) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.product   <= acc_next[2*WIDTH-1:0];
          end
        end
        DONE: begin
          // Operands are refused here even if the product leaves this cycle.
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
